k2red_ln_unscale: RTL

Sequential post-processor that removes the k^2 (or k) scaling factor left on residues by the K2-RED shift reducers for Proth-style primes q = k·2^M + 1. Since k·2^M ≡ −1 (mod q), k^-1 ≡ −2^M and k^-2 ≡ 2^(2M) (mod q). The block therefore computes C·k^-pow mod q by iterated modular doubling, with no multiplier. It sits after the reducer output stream, behind a valid/ready handshake, and produces a fully reduced residue.

---
 rtl/k2red_pkg.sv | 16 +
 rtl/k2red_moddbl.sv | 16 +
 rtl/k2red_ln_unscale.sv | 120 ++++++++++++
 3 files changed

// File: rtl/k2red_pkg.sv
// Shared definitions for the K2-RED k-factor removal post-processor.
package k2red_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Number of modular doublings needed to remove k (pow=0) or k^2 (pow=1).
  function automatic int unsigned dbl_count(input int unsigned m, input logic pow);
    return pow ? (2 * m) : m;
  endfunction

endpackage

// File: rtl/k2red_moddbl.sv
// One combinational modular doubling step: y = 2x mod q, for x < q.
module k2red_moddbl #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_q,
  output logic [W-1:0] o_y
);

  logic [W-1:0] w_dbl;

  // x < q < 2^(W-1), so the shifted value always fits in W bits.
  assign w_dbl = i_x << 1;
  assign o_y   = (w_dbl >= i_q) ? (w_dbl - i_q) : w_dbl;

endmodule

// File: rtl/k2red_ln_unscale.sv
// Removes the k or k^2 factor from a K2-RED residue by iterated modular doubling.
module k2red_ln_unscale
  import k2red_pkg::*;
#(
  parameter int unsigned LOG_Q = 32,
  parameter int unsigned M     = 17,
  parameter int unsigned STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOG_Q-1:0] C,
  input  logic [LOG_Q-1:0] Q,
  input  logic             pow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG_Q-1:0] R
);

  localparam int unsigned XW = LOG_Q + 1;
  localparam int unsigned CW = $clog2(2 * M + 1);

  state_t           r_state;
  logic [LOG_Q-1:0] r_q;
  logic             r_pow;
  logic [CW-1:0]    r_cnt;
  logic [XW-1:0]    r_x;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [LOG_Q-1:0] r_r;

  logic [LOG_Q-1:0] w_c_red;
  logic [XW-1:0]    w_q_ext;
  logic [XW-1:0]    w_neg;
  logic [XW-1:0]    w_fixed;
  logic [XW-1:0]    w_next_x;
  logic [CW-1:0]    w_applied;
  logic [XW-1:0]    w_chain [STEPS+1];

  // C < 2^LOG_Q < 2Q, so one conditional subtraction fully reduces it.
  assign w_c_red = (C >= Q) ? (C - Q) : C;
  assign w_q_ext = {1'b0, r_q};
  assign w_neg   = w_q_ext - r_x;
  assign w_fixed = (!r_pow && (r_x != '0)) ? w_neg : r_x;

  assign w_chain[0] = r_x;

  // Chain of STEPS doubling stages evaluated within one cycle.
  for (genvar g = 0; g < int'(STEPS); g++) begin : g_dbl
    k2red_moddbl #(.W(XW)) u_dbl (
      .i_x(w_chain[g]),
      .i_q(w_q_ext),
      .o_y(w_chain[g+1])
    );
  end

  // Select the chain tap for min(STEPS, cnt) doublings.
  always_comb begin
    w_next_x = w_chain[0];
    for (int i = 1; i <= int'(STEPS); i++) begin
      if (CW'(i) <= r_cnt) w_next_x = w_chain[i];
    end
  end

  assign w_applied = (r_cnt >= CW'(STEPS)) ? CW'(STEPS) : r_cnt;

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_q         <= '0;
      r_pow       <= 1'b0;
      r_cnt       <= '0;
      r_x         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_r         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_q        <= Q;
            r_pow      <= pow;
            r_cnt      <= CW'(dbl_count(M, pow));
            r_x        <= {1'b0, w_c_red};
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_x   <= w_next_x;
          r_cnt <= r_cnt - w_applied;
          if (r_cnt <= CW'(STEPS)) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_x         <= w_fixed;
          r_r         <= w_fixed[LOG_Q-1:0];
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign R         = r_r;

endmodule
